// File: rtl/tft_video_source.sv
// ---------------------------------------------------------------------------
// tft_video_source
//
// Locks onto the ULA raster timing and re-expresses each ULA pixel as a
// 320x240 window coordinate plus colour for a TFT panel writer on the same
// clock. A three-state lock FSM (UNLOCKED / SYNCING / LOCKED) only trusts the
// raster once two consecutive frame starts are exactly one frame apart.
//
// Ports
//   clk          system clock (14 MHz)
//   rst          synchronous reset, active high
//   pix_ce       ULA pixel enable, one clk pulse every 2 clk
//   ula_hc/vc    ULA horizontal / vertical counters (9 bit)
//   ula_r/g/b    ULA colour (3 bit each)
//   test_mode    colour-bar select (only acts with TFT_TEST_PATTERN_EN)
//   hc/vc        window coordinate, 9'h1FF while not locked
//   r/g/b        window colour, zero outside the window or while not locked
//   locked       high while the lock FSM is in LOCKED
//   frame_start  one-clk pulse at each locked frame origin
//
// Build option
//   TFT_TEST_PATTERN_EN  when defined, test_mode=1 replaces in-window colour
//                        with eight vertical colour bars while locked.
// ---------------------------------------------------------------------------
module tft_video_source #(
   parameter int H_TOTAL  = 448,
   parameter int V_TOTAL  = 312,
   parameter int H_ORIGIN = 416,
   parameter int V_ORIGIN = 288
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_ce,
   input  logic [8:0] ula_hc,
   input  logic [8:0] ula_vc,
   input  logic [2:0] ula_r,
   input  logic [2:0] ula_g,
   input  logic [2:0] ula_b,
   input  logic       test_mode,
   output logic [8:0] hc,
   output logic [8:0] vc,
   output logic [2:0] r,
   output logic [2:0] g,
   output logic [2:0] b,
   output logic       locked,
   output logic       frame_start
);

   localparam logic [1:0] ST_UNLOCKED = 2'd0;
   localparam logic [1:0] ST_SYNCING  = 2'd1;
   localparam logic [1:0] ST_LOCKED   = 2'd2;

   localparam logic [17:0] FRAME_PIX  = 18'(H_TOTAL * V_TOTAL);
   localparam logic [17:0] FRAME_LAST = FRAME_PIX - 18'd1;

   logic [1:0]  state_reg, state_next;
   logic [17:0] pcnt_reg, pcnt_next;
   logic        fs;
   logic        frame_ok;

   assign fs       = pix_ce & (ula_hc == 9'd0) & (ula_vc == 9'd0);
   // The pixel before an FS is number FRAME_PIX-1 when the frame was whole.
   assign frame_ok = (pcnt_reg == FRAME_LAST);

   always_comb begin
      state_next = state_reg;
      pcnt_next  = pcnt_reg;
      if (fs) begin
         pcnt_next = '0;
         case (state_reg)
            ST_UNLOCKED: state_next = ST_SYNCING;
            ST_SYNCING,
            ST_LOCKED:   state_next = frame_ok ? ST_LOCKED : ST_SYNCING;
            default:     state_next = ST_UNLOCKED;
         endcase
      end else begin
         if (pix_ce) begin
            pcnt_next = pcnt_reg + 18'd1;
            // Counting past a whole frame without an FS means the raster is gone.
            if (state_reg != ST_UNLOCKED && frame_ok)
               state_next = ST_UNLOCKED;
         end
         if (state_reg > ST_LOCKED)
            state_next = ST_UNLOCKED;
      end
   end

   // Modular coordinate remap: one subtract, then add the total back on borrow.
   logic [9:0] hdiff, vdiff, hwrap, vwrap;
   logic [8:0] ox, oy;
   logic       in_window;

   assign hdiff     = {1'b0, ula_hc} - 10'(H_ORIGIN);
   assign vdiff     = {1'b0, ula_vc} - 10'(V_ORIGIN);
   assign hwrap     = hdiff[9] ? hdiff + 10'(H_TOTAL) : hdiff;
   assign vwrap     = vdiff[9] ? vdiff + 10'(V_TOTAL) : vdiff;
   assign ox        = hwrap[8:0];
   assign oy        = vwrap[8:0];
   assign in_window = (ox < 9'd320) && (oy < 9'd240);

   logic [2:0] pix_r, pix_g, pix_b;

`ifdef TFT_TEST_PATTERN_EN
   // Eight 32-pixel-wide bars; bar index bits select B, R, G respectively.
   logic [2:0] bar;
   assign bar = ox[7:5];

   always_comb begin
      pix_r = ula_r;
      pix_g = ula_g;
      pix_b = ula_b;
      if (test_mode) begin
         pix_r = {3{bar[1]}};
         pix_g = {3{bar[2]}};
         pix_b = {3{bar[0]}};
      end
   end
`else
   assign pix_r = ula_r;
   assign pix_g = ula_g;
   assign pix_b = ula_b;
`endif

   // Carry bits of the remap are always zero after wrapping; test_mode is
   // idle in the default build.
   logic unused_bits;
   assign unused_bits = ^{test_mode, hwrap[9], vwrap[9]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_UNLOCKED;
         pcnt_reg    <= '0;
         hc          <= 9'h1FF;
         vc          <= 9'h1FF;
         r           <= '0;
         g           <= '0;
         b           <= '0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pcnt_reg    <= pcnt_next;
         locked      <= (state_next == ST_LOCKED);
         frame_start <= fs && (state_next == ST_LOCKED);
         // Blank immediately on leaving LOCKED so the writer never sees a
         // coordinate from an untrusted raster.
         if (state_next != ST_LOCKED) begin
            hc <= 9'h1FF;
            vc <= 9'h1FF;
            r  <= '0;
            g  <= '0;
            b  <= '0;
         end else if (pix_ce) begin
            hc <= ox;
            vc <= oy;
            r  <= in_window ? pix_r : 3'd0;
            g  <= in_window ? pix_g : 3'd0;
            b  <= in_window ? pix_b : 3'd0;
         end
      end
   end

endmodule

// File: tb/tb_tft_video_source.sv
// ---------------------------------------------------------------------------
// tb_tft_video_source
//
// Two instances with small rasters so whole frames fit in a short run:
//   dut_h : 330 x 4   (origin 300,2)   exercises the x>=320 window edge
//   dut_v : 4   x 250 (origin 1,200)   exercises the y>=240 window edge
// A frame-level model predicts every output on every clk; literal checks
// pin the model at hand-computed raster points.
// ---------------------------------------------------------------------------
module tb_tft_video_source;

   localparam int HH = 330, HV = 4,   HHO = 300, HVO = 2;
   localparam int VH = 4,   VV = 250, VHO = 1,   VVO = 200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, pix_ce, test_mode;
   logic [8:0] h_uhc, h_uvc, v_uhc, v_uvc;
   logic [2:0] h_ur, h_ug, h_ub, v_ur, v_ug, v_ub;
   logic [8:0] h_hc, h_vc, v_hc, v_vc;
   logic [2:0] h_r, h_g, h_b, v_r, v_g, v_b;
   logic       h_locked, h_fs, v_locked, v_fs;

   // Colour is a fixed function of the raster position so it is traceable.
   assign h_ur = h_uhc[2:0];
   assign h_ug = h_uvc[2:0];
   assign h_ub = h_uhc[5:3];
   assign v_ur = v_uhc[2:0];
   assign v_ug = v_uvc[2:0];
   assign v_ub = v_uhc[5:3];

   tft_video_source #(.H_TOTAL(HH), .V_TOTAL(HV), .H_ORIGIN(HHO), .V_ORIGIN(HVO)) dut_h (
      .clk(clk), .rst(rst), .pix_ce(pix_ce), .ula_hc(h_uhc), .ula_vc(h_uvc),
      .ula_r(h_ur), .ula_g(h_ug), .ula_b(h_ub), .test_mode(test_mode),
      .hc(h_hc), .vc(h_vc), .r(h_r), .g(h_g), .b(h_b),
      .locked(h_locked), .frame_start(h_fs));

   tft_video_source #(.H_TOTAL(VH), .V_TOTAL(VV), .H_ORIGIN(VHO), .V_ORIGIN(VVO)) dut_v (
      .clk(clk), .rst(rst), .pix_ce(pix_ce), .ula_hc(v_uhc), .ula_vc(v_uvc),
      .ula_r(v_ur), .ula_g(v_ug), .ula_b(v_ub), .test_mode(test_mode),
      .hc(v_hc), .vc(v_vc), .r(v_r), .g(v_g), .b(v_b),
      .locked(v_locked), .frame_start(v_fs));

   int nerr = 0;
   int nchk = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // st: 0 = no lock, 1 = one frame start seen, 2 = frames verified whole.
   typedef struct {
      int st;
      int cnt;    // pixels seen since the last frame start
      int hc, vc, r, g, b;
      bit locked, fso;
   } model_t;

   function automatic model_t mstep(model_t m, logic rst_i, logic ce, int uhc, int uvc,
                                    int ur, int ug, int ub, logic tm,
                                    int ht, int vt, int ho, int vo);
      int  fp, ox, oy, bar;
      bit  fs;
      fp = ht * vt;
      if (rst_i) begin
         m.st = 0; m.cnt = 0; m.hc = 511; m.vc = 511;
         m.r = 0; m.g = 0; m.b = 0; m.locked = 0; m.fso = 0;
         return m;
      end
      fs = ce && uhc == 0 && uvc == 0;
      if (fs) begin
         if (m.st == 0) m.st = 1;
         else m.st = (m.cnt == fp - 1) ? 2 : 1;
         m.cnt = 0;
      end else if (ce) begin
         m.cnt++;
         if (m.st != 0 && m.cnt == fp) m.st = 0;
      end
      m.locked = (m.st == 2);
      m.fso    = fs && (m.st == 2);
      if (m.st != 2) begin
         m.hc = 511; m.vc = 511; m.r = 0; m.g = 0; m.b = 0;
      end else if (ce) begin
         ox = (uhc - ho + ht) % ht;
         oy = (uvc - vo + vt) % vt;
         m.hc = ox;
         m.vc = oy;
         if (ox < 320 && oy < 240) begin
            m.r = ur; m.g = ug; m.b = ub;
`ifdef TFT_TEST_PATTERN_EN
            if (tm) begin
               bar = (ox / 32) % 8;
               m.r = ((bar / 2) % 2) * 7;
               m.g = ((bar / 4) % 2) * 7;
               m.b = (bar % 2) * 7;
            end
`endif
         end else begin
            m.r = 0; m.g = 0; m.b = 0;
         end
      end
      return m;
   endfunction

   function automatic logic [31:0] pack_m(model_t m);
      return {3'b0, 9'(m.hc), 9'(m.vc), 3'(m.r), 3'(m.g), 3'(m.b), m.locked, m.fso};
   endfunction

   model_t     mh, mv;
   logic       cap_ce, cap_tm;
   int         cap_hhc, cap_hvc, cap_vhc, cap_vvc;
   bit         checking = 0;
   bit         hold_pending = 0;
   int         fs_cnt_h = 0, fs_cnt_v = 0;

   always @(posedge clk) begin
      mh = mstep(mh, rst, pix_ce, int'(h_uhc), int'(h_uvc), int'(h_ur), int'(h_ug), int'(h_ub),
                 test_mode, HH, HV, HHO, HVO);
      mv = mstep(mv, rst, pix_ce, int'(v_uhc), int'(v_uvc), int'(v_ur), int'(v_ug), int'(v_ub),
                 test_mode, VH, VV, VHO, VVO);
      cap_ce  = pix_ce;
      cap_tm  = test_mode;
      cap_hhc = int'(h_uhc);
      cap_hvc = int'(h_uvc);
      cap_vhc = int'(v_uhc);
      cap_vvc = int'(v_uvc);
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      bit pat;
      if (checking) begin
         chk("dut_h outputs", {3'b0, h_hc, h_vc, h_r, h_g, h_b, h_locked, h_fs}, pack_m(mh));
         chk("dut_v outputs", {3'b0, v_hc, v_vc, v_r, v_g, v_b, v_locked, v_fs}, pack_m(mv));
         if (h_fs) fs_cnt_h++;
         if (v_fs) fs_cnt_v++;
`ifdef TFT_TEST_PATTERN_EN
         pat = cap_tm;
`else
         pat = 1'b0;
`endif
         if (hold_pending) begin
            chk("origin hold hc/vc", {h_hc, h_vc}, 18'h0);
            hold_pending = 0;
         end
         if (cap_ce && mh.st == 2) begin
            if (cap_hhc == 300 && cap_hvc == 2) begin
               chk("origin hc/vc", {h_hc, h_vc}, 18'h0);
               if (!pat) chk("origin colour", {h_r, h_g, h_b}, 9'o425);
               hold_pending = 1;
            end
            if (cap_hhc == 0 && cap_hvc == 0) chk("ula 0,0 map", {h_hc, h_vc}, {9'd30, 9'd2});
            if (cap_hhc == 290) begin
               chk("x=320 hc", h_hc, 9'd320);
               chk("x=320 colour", {h_r, h_g, h_b}, 9'o000);
            end
            if (cap_hhc == 289) begin
               chk("x=319 hc", h_hc, 9'd319);
               if (!pat) chk("x=319 red", h_r, 3'd1);
            end
            if (cap_hhc == 66 && cap_hvc == 2) begin
               chk("x=96 hc/vc", {h_hc, h_vc}, {9'd96, 9'd0});
               chk("x=96 colour", {h_r, h_g, h_b}, pat ? 9'o707 : 9'o220);
            end
         end
         if (cap_ce && mv.st == 2 && cap_vhc == 1) begin
            if (cap_vvc == 0) chk("ula vc 0 map", {v_hc, v_vc}, {9'd0, 9'd50});
            if (cap_vvc == 199) begin
               chk("y=249 vc", v_vc, 9'd249);
               chk("y=249 colour", {v_r, v_g, v_b}, 9'o000);
            end
            if (cap_vvc == 189) begin
               chk("y=239 vc", v_vc, 9'd239);
               chk("y=239 colour", {v_r, v_g, v_b}, pat ? 9'o000 : 9'o150);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic advance();
      if (h_uhc == 9'(HH - 1)) begin
         h_uhc = 0;
         h_uvc = (h_uvc == 9'(HV - 1)) ? 9'd0 : h_uvc + 9'd1;
      end else h_uhc = h_uhc + 9'd1;
      if (v_uhc == 9'(VH - 1)) begin
         v_uhc = 0;
         v_uvc = (v_uvc == 9'(VV - 1)) ? 9'd0 : v_uvc + 9'd1;
      end else v_uhc = v_uhc + 9'd1;
   endtask

   // One ULA pixel: enable for one clk, idle for one clk.
   task automatic pix(input bit adv);
      pix_ce = 1'b1;
      tick();
      pix_ce = 1'b0;
      if (adv) advance();
      tick();
   endtask

   initial begin
      rst = 1'b1; pix_ce = 1'b0; test_mode = 1'b0;
      h_uhc = 0; h_uvc = 0; v_uhc = 0; v_uvc = 0;
      repeat (3) tick();
      checking = 1;
      chk("reset outputs h", {h_hc, h_vc, h_r, h_g, h_b, h_locked, h_fs}, {9'h1FF, 9'h1FF, 9'd0, 2'b00});
      $display("reset: hc=%0h vc=%0h locked=%0b", h_hc, h_vc, h_locked);
      rst = 1'b0;

      // Clean stream starting on an FS: lock only after the second FS.
      repeat (1320) pix(1);
      chk("unlocked after frame 1", h_locked, 1'b0);
      $display("frame 1 done: locked=%0b", h_locked);
      pix(1);
      chk("locked after FS 2", h_locked, 1'b1);
      repeat (2640) pix(1);
      chk("frame_start count h", fs_cnt_h, 3);
      chk("frame_start count v", fs_cnt_v, 3);
      $display("lock stream: fs_h=%0d fs_v=%0d", fs_cnt_h, fs_cnt_v);

      // A frame with the colour-bar select raised.
      test_mode = 1'b1;
      repeat (1320) pix(1);
      test_mode = 1'b0;
      $display("test_mode frame done");

      // Early FS on dut_h drops it to SYNCING; one whole frame re-locks it.
      repeat (1000) pix(1);
      h_uhc = 0; h_uvc = 0;
      pix(1);
      chk("early FS locked", h_locked, 1'b0);
      chk("early FS hc", h_hc, 9'h1FF);
      repeat (1320) pix(1);
      chk("relock after early FS", h_locked, 1'b1);
      chk("dut_v stays locked", v_locked, 1'b1);
      $display("early FS: relocked=%0b", h_locked);

      // Pixel enable stalls, then a frame's worth of pixels with no FS.
      repeat (20) tick();
      chk("stall keeps lock", h_locked, 1'b1);
      h_uhc = 5; h_uvc = 1; v_uhc = 2; v_uvc = 3;
      repeat (1320) pix(0);
      chk("timeout h", h_locked, 1'b0);
      chk("timeout v", v_locked, 1'b0);
      $display("timeout: h_locked=%0b v_locked=%0b", h_locked, v_locked);

      // Re-lock, then reset mid-frame with pix_ce and an FS on the same clk.
      h_uhc = 0; h_uvc = 0; v_uhc = 0; v_uvc = 0;
      repeat (1500) pix(1);
      chk("relocked before reset", h_locked, 1'b1);
      h_uhc = 0; h_uvc = 0;
      pix_ce = 1'b1;
      rst = 1'b1;
      tick();
      chk("mid-frame reset h", {h_hc, h_vc, h_r, h_g, h_b, h_locked, h_fs}, {9'h1FF, 9'h1FF, 9'd0, 2'b00});
      chk("mid-frame reset v", {v_hc, v_vc, v_r, v_g, v_b, v_locked, v_fs}, {9'h1FF, 9'h1FF, 9'd0, 2'b00});
      $display("mid-frame reset: hc=%0h locked=%0b", h_hc, h_locked);
      rst = 1'b0;
      pix_ce = 1'b0;
      tick();
      repeat (500) pix(1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
